regfile_access_ctrl: RTL and testbench

REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

---
 rtl/regfile_access_ctrl_pkg.sv | 33 +++
 rtl/regfile_access_ctrl_if.sv | 65 ++++++
 rtl/regfile_access_ctrl_scoreboard.sv | 42 ++++
 rtl/regfile_access_ctrl.sv | 110 +++++++++++
 tb/tb_regfile_access_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_access_ctrl_pkg.sv
// Shared types and constants for the register-file access controller.
// Holds the controller FSM encoding, the latched issue request layout
// and a population-count helper used by the busy scoreboard.
package regfile_access_ctrl_pkg;

  localparam int REG_W  = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 1 << ADDR_W;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic              rs1_use;
    logic              rs2_use;
    logic              rd_use;
  } req_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [NREG-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Issue, operand, writeback and register-file port bundle of the controller.
// master = upstream/environment side, slave = the controller itself.
// Purely wiring: no state, no latency.
interface regfile_access_ctrl_if;
  import regfile_access_ctrl_pkg::*;

  logic              iss_valid;
  logic              iss_ready;
  logic [ADDR_W-1:0] iss_rs1;
  logic [ADDR_W-1:0] iss_rs2;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_rs1_use;
  logic              iss_rs2_use;
  logic              iss_rd_use;

  logic              op_valid;
  logic              op_ready;
  logic [REG_W-1:0]  op_a;
  logic [REG_W-1:0]  op_b;
  logic [ADDR_W-1:0] op_rd;
  logic              op_rd_use;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [REG_W-1:0]  wb_data;

  logic              rf_rd0_en;
  logic              rf_rd1_en;
  logic [ADDR_W-1:0] rf_rd0_addr;
  logic [ADDR_W-1:0] rf_rd1_addr;
  logic [REG_W-1:0]  rf_rd0_data;
  logic [REG_W-1:0]  rf_rd1_data;

  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [REG_W-1:0]  rf_wr_data;

  logic [CNT_W-1:0]  pending_cnt;
  logic              wb_err;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rs1_use, iss_rs2_use, iss_rd_use,
    input  iss_ready,
    input  op_valid, op_a, op_b, op_rd, op_rd_use,
    output op_ready,
    output wb_valid, wb_addr, wb_data,
    input  rf_rd0_en, rf_rd1_en, rf_rd0_addr, rf_rd1_addr,
    output rf_rd0_data, rf_rd1_data,
    input  rf_wr_en, rf_wr_addr, rf_wr_data,
    input  pending_cnt, wb_err
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rs1_use, iss_rs2_use, iss_rd_use,
    output iss_ready,
    output op_valid, op_a, op_b, op_rd, op_rd_use,
    input  op_ready,
    input  wb_valid, wb_addr, wb_data,
    output rf_rd0_en, rf_rd1_en, rf_rd0_addr, rf_rd1_addr,
    input  rf_rd0_data, rf_rd1_data,
    output rf_wr_en, rf_wr_addr, rf_wr_data,
    output pending_cnt, wb_err
  );

endinterface

// File: rtl/regfile_access_ctrl_scoreboard.sv
// Busy scoreboard: one bit per architectural register plus a registered count.
// Latency: set/clear visible on busy_o and cnt_o the cycle after the request.
// No backpressure: set and clear are always applied; a same-cycle set beats a clear.
module regfile_scoreboard
  import regfile_access_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  output logic [NREG-1:0]   busy_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [NREG-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q;

  // Clear first, then set, so an issue claiming the register being retired keeps it busy; x0 is never tracked.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy vector and its population count move together so the count always matches busy_o.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= popcount(busy_d);
    end
  end

  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/regfile_access_ctrl.sv
// Issue-side register-file access: hazard check, operand read, writeback and busy tracking.
// Latency: accept in N, register-file read in N+1, operands valid from N+2.
// Backpressure: iss_ready low on hazard or while held operands wait on op_ready; writebacks never stall.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_access_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  logic [REG_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic             wb_err_q, wb_err_d;
  logic [NREG-1:0]  busy;
  logic [CNT_W-1:0] cnt;
  logic             hazard, can_issue, accept, set_en;

  // RAW on used nonzero sources or WAW on a used nonzero destination; no writeback forwarding.
  always_comb begin
    hazard = 1'b0;
    if (bus.iss_rs1_use && bus.iss_rs1 != '0 && busy[bus.iss_rs1]) hazard = 1'b1;
    if (bus.iss_rs2_use && bus.iss_rs2 != '0 && busy[bus.iss_rs2]) hazard = 1'b1;
    if (bus.iss_rd_use  && bus.iss_rd  != '0 && busy[bus.iss_rd])  hazard = 1'b1;
  end

  assign can_issue     = (state_q == ST_IDLE) || (state_q == ST_HOLD && bus.op_ready);
  assign bus.iss_ready = reset_n && can_issue && !hazard;
  assign accept        = bus.iss_valid && bus.iss_ready;
  assign set_en        = accept && bus.iss_rd_use && bus.iss_rd != '0;

  // Next state, request latch and operand capture; a new accept overrides the HOLD->IDLE return.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    case (state_q)
      ST_IDLE: ;
      ST_READ: begin
        op_a_d  = (req_q.rs1_use && req_q.rs1 != '0) ? bus.rf_rd0_data : '0;
        op_b_d  = (req_q.rs2_use && req_q.rs2 != '0) ? bus.rf_rd1_data : '0;
        state_d = ST_HOLD;
      end
      ST_HOLD: if (bus.op_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d       = ST_READ;
      req_d.rs1     = bus.iss_rs1;
      req_d.rs2     = bus.iss_rs2;
      req_d.rd      = bus.iss_rd;
      req_d.rs1_use = bus.iss_rs1_use;
      req_d.rs2_use = bus.iss_rs2_use;
      req_d.rd_use  = bus.iss_rd_use;
    end
  end

  // Writes to a register nobody is waiting on are flagged and the flag sticks until reset.
  always_comb begin
    wb_err_d = wb_err_q;
    if (bus.wb_valid && bus.wb_addr != '0 && !busy[bus.wb_addr]) wb_err_d = 1'b1;
  end

  // Controller state; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      wb_err_q <= wb_err_d;
    end
  end

  regfile_scoreboard u_sb (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_en_i   (set_en),
    .set_addr_i (bus.iss_rd),
    .clr_en_i   (bus.wb_valid && reset_n),
    .clr_addr_i (bus.wb_addr),
    .busy_o     (busy),
    .cnt_o      (cnt)
  );

  // Outputs are forced quiet while reset is held, independent of the registered state.
  assign bus.rf_rd0_en   = reset_n && state_q == ST_READ && req_q.rs1_use;
  assign bus.rf_rd1_en   = reset_n && state_q == ST_READ && req_q.rs2_use;
  assign bus.rf_rd0_addr = req_q.rs1;
  assign bus.rf_rd1_addr = req_q.rs2;
  assign bus.op_valid    = reset_n && state_q == ST_HOLD;
  assign bus.op_a        = reset_n ? op_a_q : '0;
  assign bus.op_b        = reset_n ? op_b_q : '0;
  assign bus.op_rd       = reset_n ? req_q.rd : '0;
  assign bus.op_rd_use   = reset_n && req_q.rd_use;
  assign bus.rf_wr_en    = reset_n && bus.wb_valid && bus.wb_addr != '0;
  assign bus.rf_wr_addr  = bus.wb_addr;
  assign bus.rf_wr_data  = bus.wb_data;
  assign bus.pending_cnt = cnt;
  assign bus.wb_err      = wb_err_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed vector table, hand-written corner sequences,
// then randomized traffic against a cycle-level behavioural model of the issue rules.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_regfile_access_ctrl;
  import regfile_access_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl_if bus ();

  regfile_access_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Initial register contents: x0 deliberately nonzero so forced-zero operands are visible.
  function automatic logic [31:0] rf_init(input logic [4:0] a);
    case (a)
      5'd0:    return 32'hDEAD_BEEF;
      5'd3:    return 32'h0000_0011;
      5'd4:    return 32'h0000_0022;
      default: return 32'h0100_0000 | {27'd0, a};
    endcase
  endfunction

  // Register file driven by the DUT write port.
  logic [31:0] rf_mem [32];
  bit          rf_vld [32];
  always @(posedge clk) begin
    if (bus.rf_wr_en) begin
      rf_mem[bus.rf_wr_addr] <= bus.rf_wr_data;
      rf_vld[bus.rf_wr_addr] <= 1'b1;
    end
  end
  assign bus.rf_rd0_data = rf_vld[bus.rf_rd0_addr] ? rf_mem[bus.rf_rd0_addr] : rf_init(bus.rf_rd0_addr);
  assign bus.rf_rd1_data = rf_vld[bus.rf_rd1_addr] ? rf_mem[bus.rf_rd1_addr] : rf_init(bus.rf_rd1_addr);

  // Expected architectural register values, derived from the writeback inputs only.
  logic [31:0] ref_mem [32];
  bit          ref_vld [32];
  always @(posedge clk) begin
    if (reset_n && bus.wb_valid && bus.wb_addr != 5'd0) begin
      ref_mem[bus.wb_addr] <= bus.wb_data;
      ref_vld[bus.wb_addr] <= 1'b1;
    end
  end
  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    return ref_vld[a] ? ref_mem[a] : rf_init(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_iss(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic ud);
    bus.iss_valid = v;   bus.iss_rs1 = rs1;     bus.iss_rs2 = rs2;     bus.iss_rd = rd;
    bus.iss_rs1_use = u1; bus.iss_rs2_use = u2; bus.iss_rd_use = ud;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.wb_valid = v; bus.wb_addr = a; bus.wb_data = d;
  endtask

  typedef struct {
    logic        iv;  logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
    logic        u1;  logic u2; logic ud; logic ordy;
    logic        wv;  logic [4:0] wa; logic [31:0] wd;
    logic        e_irdy; logic e_ovld; logic [31:0] e_a; logic [31:0] e_b; logic [4:0] e_rd;
    logic [5:0]  e_cnt; logic e_rd0en; logic [4:0] e_rd0a; logic e_wren; logic e_err;
  } vec_t;

  function automatic vec_t mk(input int iv, rs1, rs2, rd, u1, u2, ud, ordy, wv, wa, wd,
                              input int irdy, ovld, a, b, rdo, cnt, rd0en, rd0a, wren, err);
    vec_t v;
    v.iv = 1'(iv);   v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.u1 = 1'(u1);   v.u2 = 1'(u2);   v.ud = 1'(ud);   v.ordy = 1'(ordy);
    v.wv = 1'(wv);   v.wa = 5'(wa);   v.wd = wd;
    v.e_irdy = 1'(irdy); v.e_ovld = 1'(ovld); v.e_a = a; v.e_b = b; v.e_rd = 5'(rdo);
    v.e_cnt = 6'(cnt);   v.e_rd0en = 1'(rd0en); v.e_rd0a = 5'(rd0a);
    v.e_wren = 1'(wren); v.e_err = 1'(err);
    return v;
  endfunction

  localparam int NV = 13;
  vec_t tbl [NV];

  // Randomized traffic checked against a model of the issue/writeback rules.
  task automatic run_random(input int n);
    bit [31:0]   m_busy = '0;
    bit          m_err = 1'b0, m_out = 1'b0;
    int          m_acc = 0;
    logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
    logic        m_u1 = 1'b0, m_u2 = 1'b0, m_ud = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;
    for (int cyc = 0; cyc < n; cyc++) begin
      logic [4:0] wa;
      bit hz, pres, rdg, e_rdy;
      next_cycle();
      set_iss(1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      bus.op_ready = 1'($urandom_range(0, 9) < 7);
      wa = 5'($urandom_range(0, 31));
      if (m_busy != 0 && $urandom_range(0, 4) != 0) begin
        int s = $urandom_range(0, 31);
        for (int j = 31; j >= 0; j--) if (m_busy[(s + j) % 32]) wa = 5'((s + j) % 32);
      end
      set_wb(1'($urandom_range(0, 1)), wa, $urandom);
      mid();
      hz = (bus.iss_rs1_use && bus.iss_rs1 != 0 && m_busy[bus.iss_rs1]) ||
           (bus.iss_rs2_use && bus.iss_rs2 != 0 && m_busy[bus.iss_rs2]) ||
           (bus.iss_rd_use  && bus.iss_rd  != 0 && m_busy[bus.iss_rd]);
      pres  = m_out && cyc >= m_acc + 2;
      rdg   = m_out && cyc == m_acc + 1;
      e_rdy = (!m_out || (pres && bus.op_ready)) && !hz;
      chk("rnd_iss_ready", 32'(bus.iss_ready), 32'(e_rdy));
      chk("rnd_op_valid", 32'(bus.op_valid), 32'(pres));
      if (pres) begin
        chk("rnd_op_a", bus.op_a, m_a);
        chk("rnd_op_b", bus.op_b, m_b);
        chk("rnd_op_rd", 32'(bus.op_rd), 32'(m_rd));
        chk("rnd_op_rd_use", 32'(bus.op_rd_use), 32'(m_ud));
      end
      chk("rnd_rd0_en", 32'(bus.rf_rd0_en), 32'(rdg && m_u1));
      chk("rnd_rd1_en", 32'(bus.rf_rd1_en), 32'(rdg && m_u2));
      if (rdg && m_u1) chk("rnd_rd0_addr", 32'(bus.rf_rd0_addr), 32'(m_rs1));
      if (rdg && m_u2) chk("rnd_rd1_addr", 32'(bus.rf_rd1_addr), 32'(m_rs2));
      chk("rnd_wr_en", 32'(bus.rf_wr_en), 32'(bus.wb_valid && bus.wb_addr != 0));
      if (bus.wb_valid && bus.wb_addr != 0) chk("rnd_wr_data", bus.rf_wr_data, bus.wb_data);
      chk("rnd_pending", 32'(bus.pending_cnt), $countones(m_busy));
      chk("rnd_wb_err", 32'(bus.wb_err), 32'(m_err));
      // advance the model by one clock
      if (rdg) begin
        m_a = (m_u1 && m_rs1 != 0) ? ref_rd(m_rs1) : 32'd0;
        m_b = (m_u2 && m_rs2 != 0) ? ref_rd(m_rs2) : 32'd0;
      end
      if (pres && bus.op_ready) m_out = 1'b0;
      if (bus.wb_valid) begin
        if (bus.wb_addr != 0 && !m_busy[bus.wb_addr]) m_err = 1'b1;
        m_busy[bus.wb_addr] = 1'b0;
      end
      if (bus.iss_valid && e_rdy) begin
        if (bus.iss_rd_use && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
        m_out = 1'b1; m_acc = cyc;
        m_rs1 = bus.iss_rs1; m_rs2 = bus.iss_rs2; m_rd = bus.iss_rd;
        m_u1 = bus.iss_rs1_use; m_u2 = bus.iss_rs2_use; m_ud = bus.iss_rd_use;
      end
    end
  endtask

  initial begin
    //             iv rs1 rs2 rd u1 u2 ud ordy wv wa wd     irdy ovld a     b     rd cnt rd0en rd0a wren err
    tbl[0]  = mk(1, 3, 4, 5, 1, 1, 1, 1, 0, 0, 0,     1, 0, 0,    0,    0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,     0, 0, 0,    0,    0, 1, 1, 3, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 1, 'h11, 'h22, 5, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0,     0, 1, 'h11, 'h22, 5, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0,     0, 0, 0,    0,    0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 5, 0, 0, 1, 0, 0, 1, 1, 5, 'hAB,  0, 0, 0,    0,    0, 1, 0, 0, 1, 0);
    tbl[6]  = mk(1, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0,     1, 0, 0,    0,    0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,     0, 0, 0,    0,    0, 0, 1, 5, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,     1, 1, 'hAB, 0,    0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 4, 0, 1, 1, 0, 1, 0, 0, 0,     1, 0, 0,    0,    0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h55,  0, 0, 0,    0,    0, 0, 1, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,     1, 1, 0,    'h22, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,     1, 0, 0,    0,    0, 0, 0, 0, 0, 0);

    // Reset with live-looking inputs: everything must stay quiet.
    reset_n = 1'b0;
    set_iss(1, 5'd3, 5'd4, 5'd5, 1, 1, 1);
    bus.op_ready = 1'b1;
    set_wb(1, 5'd3, 32'hFFFF_FFFF);
    @(posedge clk); @(posedge clk);
    mid();
    chk("rst_iss_ready", 32'(bus.iss_ready), 32'd0);
    chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
    chk("rst_op_a", bus.op_a, 32'd0);
    chk("rst_op_rd", 32'(bus.op_rd), 32'd0);
    chk("rst_rd_en", 32'({bus.rf_rd0_en, bus.rf_rd1_en}), 32'd0);
    chk("rst_wr_en", 32'(bus.rf_wr_en), 32'd0);
    chk("rst_pending", 32'(bus.pending_cnt), 32'd0);
    chk("rst_wb_err", 32'(bus.wb_err), 32'd0);
    next_cycle();
    reset_n = 1'b1;
    set_iss(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0);

    // Directed table: basic read, RAW stall released by writeback, x0 handling.
    for (int i = 0; i < NV; i++) begin
      vec_t t;
      t = tbl[i];
      next_cycle();
      set_iss(t.iv, t.rs1, t.rs2, t.rd, t.u1, t.u2, t.ud);
      bus.op_ready = t.ordy;
      set_wb(t.wv, t.wa, t.wd);
      mid();
      chk($sformatf("v%0d_iss_ready", i), 32'(bus.iss_ready), 32'(t.e_irdy));
      chk($sformatf("v%0d_op_valid", i), 32'(bus.op_valid), 32'(t.e_ovld));
      chk($sformatf("v%0d_pending", i), 32'(bus.pending_cnt), 32'(t.e_cnt));
      chk($sformatf("v%0d_rd0_en", i), 32'(bus.rf_rd0_en), 32'(t.e_rd0en));
      chk($sformatf("v%0d_wr_en", i), 32'(bus.rf_wr_en), 32'(t.e_wren));
      chk($sformatf("v%0d_wb_err", i), 32'(bus.wb_err), 32'(t.e_err));
      if (t.e_rd0en) chk($sformatf("v%0d_rd0_addr", i), 32'(bus.rf_rd0_addr), 32'(t.e_rd0a));
      if (t.e_ovld) begin
        chk($sformatf("v%0d_op_a", i), bus.op_a, t.e_a);
        chk($sformatf("v%0d_op_b", i), bus.op_b, t.e_b);
        chk($sformatf("v%0d_op_rd", i), 32'(bus.op_rd), 32'(t.e_rd));
      end
    end

    // Stalled consumer for five cycles, then back-to-back accept on release.
    next_cycle(); set_iss(1, 5'd3, 5'd4, 5'd8, 1, 1, 1); bus.op_ready = 1'b0;
    mid(); chk("hold_accept", 32'(bus.iss_ready), 32'd1);
    next_cycle(); set_iss(1, 5'd1, 5'd2, 5'd9, 1, 1, 1);
    mid(); chk("hold_read_vld", 32'(bus.op_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      next_cycle(); mid();
      chk($sformatf("hold%0d_vld", i), 32'(bus.op_valid), 32'd1);
      chk($sformatf("hold%0d_a", i), bus.op_a, 32'h11);
      chk($sformatf("hold%0d_b", i), bus.op_b, 32'h22);
      chk($sformatf("hold%0d_rd", i), 32'(bus.op_rd), 32'd8);
      chk($sformatf("hold%0d_rdy", i), 32'(bus.iss_ready), 32'd0);
    end
    next_cycle(); bus.op_ready = 1'b1;
    mid(); chk("b2b_vld", 32'(bus.op_valid), 32'd1); chk("b2b_rdy", 32'(bus.iss_ready), 32'd1);
    chk("b2b_a", bus.op_a, 32'h11);
    next_cycle(); set_iss(0, 0, 0, 0, 0, 0, 0);
    mid(); chk("b2b_read_vld", 32'(bus.op_valid), 32'd0); chk("b2b_pending", 32'(bus.pending_cnt), 32'd2);
    next_cycle(); mid();
    chk("b2b2_vld", 32'(bus.op_valid), 32'd1); chk("b2b2_a", bus.op_a, 32'h0100_0001);
    chk("b2b2_b", bus.op_b, 32'h0100_0002); chk("b2b2_rd", 32'(bus.op_rd), 32'd9);
    next_cycle(); set_wb(1, 5'd8, 32'h88);
    mid(); chk("wb8_wr_en", 32'(bus.rf_wr_en), 32'd1);
    next_cycle(); set_wb(1, 5'd9, 32'h99);
    mid(); chk("wb9_pending", 32'(bus.pending_cnt), 32'd1);
    next_cycle(); set_wb(0, 0, 0);
    mid(); chk("wb_done_pending", 32'(bus.pending_cnt), 32'd0); chk("wb_done_err", 32'(bus.wb_err), 32'd0);

    // Writeback to a register nobody owns: flagged, sticky, and still written.
    next_cycle(); set_wb(1, 5'd7, 32'h77);
    mid(); chk("err_wr_en", 32'(bus.rf_wr_en), 32'd1); chk("err_wr_addr", 32'(bus.rf_wr_addr), 32'd7);
    chk("err_wr_data", bus.rf_wr_data, 32'h77); chk("err_not_yet", 32'(bus.wb_err), 32'd0);
    next_cycle(); set_wb(0, 0, 0);
    mid(); chk("err_set", 32'(bus.wb_err), 32'd1);
    next_cycle(); set_iss(1, 5'd7, 5'd0, 5'd0, 1, 0, 0);
    mid(); chk("err_iss_rdy", 32'(bus.iss_ready), 32'd1);
    next_cycle(); set_iss(0, 0, 0, 0, 0, 0, 0);
    next_cycle(); mid();
    chk("err_x7_vld", 32'(bus.op_valid), 32'd1); chk("err_x7_a", bus.op_a, 32'h77);
    chk("err_sticky", 32'(bus.wb_err), 32'd1);

    // Reset while the register file is being read for an rd=9 request.
    next_cycle(); set_iss(1, 5'd1, 5'd0, 5'd9, 1, 0, 1);
    mid(); chk("rr_accept", 32'(bus.iss_ready), 32'd1);
    next_cycle(); set_iss(0, 0, 0, 0, 0, 0, 0); reset_n = 1'b0;
    mid(); chk("rr_op_valid", 32'(bus.op_valid), 32'd0); chk("rr_rd0_en", 32'(bus.rf_rd0_en), 32'd0);
    chk("rr_op_rd", 32'(bus.op_rd), 32'd0); chk("rr_iss_ready", 32'(bus.iss_ready), 32'd0);
    next_cycle(); reset_n = 1'b1;
    mid(); chk("rr_idle", 32'(bus.iss_ready), 32'd1); chk("rr_pending", 32'(bus.pending_cnt), 32'd0);
    chk("rr_vld", 32'(bus.op_valid), 32'd0); chk("rr_err", 32'(bus.wb_err), 32'd0);
    next_cycle(); mid(); chk("rr_vld2", 32'(bus.op_valid), 32'd0);

    run_random(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
